// File: rtl/pulse_sync_gen.sv
// PMT-synchronised multi-channel switch driver.
// A synchronised PMT rising edge starts a delay-compensated PRT countdown; on
// expiry the block fires, toggling or pulsing the NCH switch outputs. Every
// cpi_len normal fires a CPI boundary fire (with an extra gap) resets the CPI
// counter and the switch level. Configuration is double-buffered: a shadow copy
// is captured on cfg_load and promoted only at safe points.
module pulse_sync_gen #(
    parameter int               NCH         = 2,
    parameter int               CNT_W       = 16,
    parameter int               CPI_W       = 8,
    parameter int               DEF_PRT     = 2400,
    parameter int               DEF_DELAY   = 9,
    parameter int               DEF_GAP     = 0,
    parameter int               DEF_CPI_LEN = 99,
    parameter logic [NCH-1:0]   INV_MASK    = '0
) (
    input  logic                sysclk_i,
    input  logic                rst_i,
    input  logic                pmt_i,
    input  logic                clear_i,
    input  logic [NCH-1:0]      chan_en_i,
    input  logic                cfg_load_i,
    input  logic [CNT_W-1:0]    cfg_prt_i,
    input  logic [CNT_W-1:0]    cfg_delay_i,
    input  logic [CNT_W-1:0]    cfg_gap_i,
    input  logic [CPI_W-1:0]    cfg_cpi_len_i,
    input  logic                cfg_mode_i,
    input  logic [CNT_W-1:0]    cfg_pulse_w_i,
    output logic [NCH-1:0]      switch_o,
    output logic                cpi_start_o,
    output logic [CPI_W-1:0]    cpi_count_o,
    output logic                busy_o,
    output logic                cfg_err_o,
    output logic                pmt_overrun_o
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] prt;
        logic [CNT_W-1:0] delay;
        logic [CNT_W-1:0] gap;
        logic [CPI_W-1:0] cpi_len;
        logic             mode;
        logic [CNT_W-1:0] pulse_w;
    } cfg_t;

    localparam cfg_t CFG_DEF = '{
        prt:     CNT_W'(DEF_PRT),
        delay:   CNT_W'(DEF_DELAY),
        gap:     CNT_W'(DEF_GAP),
        cpi_len: CPI_W'(DEF_CPI_LEN),
        mode:    1'b0,
        pulse_w: CNT_W'(1)
    };

    logic             pmt_meta_q, pmt_sync_q, pmt_prev_q;
    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CPI_W-1:0] cpi_q;
    logic             base_q, base_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [NCH-1:0]   switch_q, switch_d;
    logic             cpi_start_q;
    logic             cfg_err_q;
    logic             overrun_q;
    cfg_t             shd_q, shd_d;
    cfg_t             act_q, act_d;
    cfg_t             cfg_in;

    logic             rise;
    logic             cfg_bad;
    logic [CNT_W-1:0] t_norm;
    logic [CNT_W:0]   t_sum;
    logic [CNT_W-1:0] t_bnd;
    logic             at_boundary;
    logic [CNT_W-1:0] target;
    logic             fire;
    logic             xfer;

    assign cfg_in = '{
        prt:     cfg_prt_i,
        delay:   cfg_delay_i,
        gap:     cfg_gap_i,
        cpi_len: cfg_cpi_len_i,
        mode:    cfg_mode_i,
        pulse_w: cfg_pulse_w_i
    };

    assign rise        = pmt_sync_q & ~pmt_prev_q;
    assign cfg_bad     = (act_q.delay >= act_q.prt);
    // A delay that swallows the whole PRT degenerates to the shortest countdown.
    assign t_norm      = cfg_bad ? CNT_W'(1) : (act_q.prt - act_q.delay);
    assign t_sum       = {1'b0, t_norm} + {1'b0, act_q.gap};
    assign t_bnd       = t_sum[CNT_W] ? '1 : t_sum[CNT_W-1:0];
    assign at_boundary = (cpi_q == act_q.cpi_len);
    assign target      = at_boundary ? t_bnd : t_norm;
    assign fire        = (state_q == ST_WAIT) && (count_q == target);

    // Promote shadow config only between CPIs or on the boundary fire itself.
    assign xfer  = !clear_i && (((state_q == ST_IDLE) && (cpi_q == '0)) || (fire && at_boundary));
    assign shd_d = (!clear_i && cfg_load_i) ? cfg_in : shd_q;
    assign act_d = xfer ? (cfg_load_i ? cfg_in : shd_q) : act_q;

    // Next switch level: pulse timeout first, then fire action, clear overrides.
    always_comb begin
        base_d = base_q;
        pcnt_d = pcnt_q;
        if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - CNT_W'(1);
            if (pcnt_q == CNT_W'(1)) begin
                base_d = 1'b0;
            end
        end
        if (fire) begin
            if (at_boundary) begin
                base_d = 1'b0;
                pcnt_d = '0;
            end else if (act_q.mode) begin
                base_d = 1'b1;
                pcnt_d = (act_q.pulse_w == '0) ? CNT_W'(1) : act_q.pulse_w;
            end else begin
                base_d = ~base_q;
            end
        end
        if (clear_i) begin
            base_d = 1'b0;
            pcnt_d = '0;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_switch
        assign switch_d[gi] = chan_en_i[gi] ? (base_d ^ INV_MASK[gi]) : INV_MASK[gi];
    end

    // Two-flop PMT synchroniser plus edge-detect history.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            pmt_meta_q <= 1'b0;
            pmt_sync_q <= 1'b0;
            pmt_prev_q <= 1'b0;
        end else begin
            pmt_meta_q <= pmt_i;
            pmt_sync_q <= pmt_meta_q;
            pmt_prev_q <= pmt_sync_q;
        end
    end

    // Output level, pulse counter and config registers.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q   <= 1'b0;
            pcnt_q   <= '0;
            switch_q <= INV_MASK;
            shd_q    <= CFG_DEF;
            act_q    <= CFG_DEF;
        end else begin
            base_q   <= base_d;
            pcnt_q   <= pcnt_d;
            switch_q <= switch_d;
            shd_q    <= shd_d;
            act_q    <= act_d;
        end
    end

    // Countdown FSM with CPI counter, boundary strobe and sticky flags.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            cpi_q       <= '0;
            cpi_start_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cpi_start_q <= 1'b0;
            if (clear_i) begin
                state_q   <= ST_IDLE;
                count_q   <= '0;
                cpi_q     <= '0;
                cfg_err_q <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_q <= ST_WAIT;
                            count_q <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (rise) begin
                            overrun_q <= 1'b1;
                        end
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end
                        if (fire) begin
                            state_q <= ST_IDLE;
                            count_q <= '0;
                            if (at_boundary) begin
                                cpi_q       <= '0;
                                cpi_start_q <= 1'b1;
                            end else begin
                                cpi_q <= cpi_q + CPI_W'(1);
                            end
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign switch_o      = switch_q;
    assign cpi_start_o   = cpi_start_q;
    assign cpi_count_o   = cpi_q;
    assign busy_o        = (state_q == ST_WAIT);
    assign cfg_err_o     = cfg_err_q;
    assign pmt_overrun_o = overrun_q;

endmodule

// File: tb/tb_pulse_sync_gen.sv
// Testbench for pulse_sync_gen: a transaction-level model predicts fire timing,
// switch levels, CPI bookkeeping and sticky flags for each PMT pulse.
module tb_pulse_sync_gen;

    localparam logic [3:0] INV = 4'b1010;

    logic        clk = 1'b0;
    logic        rst, pmt, clr, cfg_load, cfg_mode;
    logic [3:0]  chan_en;
    logic [15:0] cfg_prt, cfg_delay, cfg_gap, cfg_pw;
    logic [7:0]  cfg_cpi_len;
    logic [3:0]  sw;
    logic        cpi_start, busy, cfg_err, ovr;
    logic [7:0]  cpi_count;

    pulse_sync_gen #(
        .NCH(4), .CNT_W(16), .CPI_W(8), .DEF_PRT(2400), .DEF_DELAY(9),
        .DEF_GAP(0), .DEF_CPI_LEN(99), .INV_MASK(INV)
    ) dut (
        .sysclk_i(clk), .rst_i(rst), .pmt_i(pmt), .clear_i(clr), .chan_en_i(chan_en),
        .cfg_load_i(cfg_load), .cfg_prt_i(cfg_prt), .cfg_delay_i(cfg_delay),
        .cfg_gap_i(cfg_gap), .cfg_cpi_len_i(cfg_cpi_len), .cfg_mode_i(cfg_mode),
        .cfg_pulse_w_i(cfg_pw), .switch_o(sw), .cpi_start_o(cpi_start),
        .cpi_count_o(cpi_count), .busy_o(busy), .cfg_err_o(cfg_err), .pmt_overrun_o(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int prt; int delay; int gap; int cpi_len; bit mode; int pw;
    } mcfg_t;

    mcfg_t m_act, m_shd, m_def;
    int    m_cpi;
    bit    m_base, m_err, m_ovr;
    int    total = 0, bad = 0;

    int         obs_busy, exp_busy, obs_plen, exp_plen, exp_cpi;
    logic [3:0] obs_sw, exp_sw;
    logic       obs_cs, exp_cs, obs_err, obs_ovr;
    logic [7:0] obs_cpi;

    function automatic mcfg_t mk(int prt, int delay, int gap, int cpi_len, bit mode, int pw);
        mcfg_t c;
        c.prt = prt; c.delay = delay; c.gap = gap; c.cpi_len = cpi_len; c.mode = mode; c.pw = pw;
        return c;
    endfunction

    // Cycles from WAIT entry to expiry: PRT minus delay (floor 1), plus gap at a boundary.
    function automatic int m_target(bit bnd);
        int t;
        t = (m_act.prt > m_act.delay) ? (m_act.prt - m_act.delay) : 1;
        if (bnd) t = t + m_act.gap;
        if (t > 65535) t = 65535;
        return t;
    endfunction

    function automatic logic [3:0] m_sw(bit b);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = chan_en[k] ? (b ^ INV[k]) : INV[k];
        return r;
    endfunction

    task automatic m_reset();
        m_act = m_def; m_shd = m_def; m_cpi = 0; m_base = 0; m_err = 0; m_ovr = 0;
    endtask

    task automatic m_clear();
        m_cpi = 0; m_base = 0; m_err = 0; m_ovr = 0; m_act = m_shd;
    endtask

    task automatic set_cfg_ports(input mcfg_t c);
        cfg_prt = 16'(c.prt); cfg_delay = 16'(c.delay); cfg_gap = 16'(c.gap);
        cfg_cpi_len = 8'(c.cpi_len); cfg_mode = c.mode; cfg_pw = 16'(c.pw);
    endtask

    task automatic load_idle(input mcfg_t c);
        set_cfg_ports(c);
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        m_shd = c;
        if (m_cpi == 0) m_act = c;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_clear();
    endtask

    // Raise pmt and wait (bounded) for WAIT entry; returns 1 if it was seen.
    task automatic start_wait(output bit ok);
        int w;
        pmt = 1'b1; w = 0;
        while (busy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        pmt = 1'b0;
        ok = (busy === 1'b1);
    endtask

    // One PMT transaction. action 1: cfg_load of pend mid-WAIT; 2: extra pmt pulse mid-WAIT.
    task automatic do_txn(input int action, input mcfg_t pend);
        bit bnd, pulsed, ok;
        int bc;
        logic [3:0] hi;
        bnd = (m_cpi == m_act.cpi_len);
        exp_busy = m_target(bnd) + 1;
        if (m_act.delay >= m_act.prt) m_err = 1;
        if (action == 2) m_ovr = 1;
        if (action == 1) begin set_cfg_ports(pend); m_shd = pend; end
        pulsed = 0; exp_plen = -1;
        if (bnd) begin
            m_base = 0; m_cpi = 0; m_act = m_shd;
        end else begin
            m_cpi++;
            if (m_act.mode) begin
                m_base = 1; pulsed = 1; exp_plen = (m_act.pw == 0) ? 1 : m_act.pw;
            end else begin
                m_base = ~m_base;
            end
        end
        exp_sw = m_sw(m_base); exp_cs = bnd; exp_cpi = m_cpi;
        start_wait(ok);
        bc = 0;
        if (ok) begin
            bc = 1;
            while (bc < 70000) begin
                @(negedge clk);
                if (busy !== 1'b1) break;
                bc++;
                if (action == 1 && bc == 4) cfg_load = 1'b1;
                if (action == 1 && bc == 5) cfg_load = 1'b0;
                if (action == 2 && bc == 4) pmt = 1'b1;
                if (action == 2 && bc == 8) pmt = 1'b0;
            end
        end
        cfg_load = 1'b0; pmt = 1'b0;
        obs_busy = bc; obs_sw = sw; obs_cs = cpi_start; obs_cpi = cpi_count;
        obs_err = cfg_err; obs_ovr = ovr; obs_plen = -1;
        if (pulsed) begin
            hi = m_sw(1'b1);
            if (hi != m_sw(1'b0)) begin
                obs_plen = 0;
                while (sw === hi && obs_plen < 20) begin obs_plen++; @(negedge clk); end
            end else begin
                exp_plen = -1;
            end
            m_base = 0;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pmt = 1'b0; clr = 1'b0; cfg_load = 1'b0; chan_en = 4'b0001;
        set_cfg_ports(mk(0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (sw !== 4'b1010) begin bad++; $display("FAIL reset_switch got=%b want=1010", sw); end
        total++; if (cpi_count !== 8'd0) begin bad++; $display("FAIL reset_cpi got=%0d want=0", cpi_count); end
        total++; if (cpi_start !== 1'b0) begin bad++; $display("FAIL reset_cpi_start got=%b want=0", cpi_start); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", ovr); end
        $display("reset: busy=%b switch=%b cpi=%0d", busy, sw, cpi_count);
    endtask

    task automatic test_defaults();
        do_txn(0, m_def);
        total++; if (obs_busy !== 2392) begin bad++; $display("FAIL def_busy got=%0d want=2392", obs_busy); end
        total++; if (obs_sw !== 4'b1011) begin bad++; $display("FAIL def_switch got=%b want=1011", obs_sw); end
        total++; if (obs_cpi !== 8'd1) begin bad++; $display("FAIL def_cpi got=%0d want=1", obs_cpi); end
        $display("defaults: busy=%0d switch=%b cpi=%0d", obs_busy, obs_sw, obs_cpi);
    endtask

    task automatic test_cpi_boundary();
        pulse_clear();
        load_idle(mk(20, 5, 10, 3, 0, 1));
        for (int i = 0; i < 4; i++) begin
            do_txn(0, m_act);
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL cpi_busy%0d got=%0d want=%0d", i, obs_busy, exp_busy); end
            total++; if (obs_sw !== exp_sw) begin bad++; $display("FAIL cpi_switch%0d got=%b want=%b", i, obs_sw, exp_sw); end
            total++; if (obs_cs !== exp_cs) begin bad++; $display("FAIL cpi_start%0d got=%b want=%b", i, obs_cs, exp_cs); end
            total++; if (obs_cpi !== 8'(exp_cpi)) begin bad++; $display("FAIL cpi_count%0d got=%0d want=%0d", i, obs_cpi, exp_cpi); end
            $display("cpi fire %0d: busy=%0d switch=%b cpi_start=%b cpi=%0d", i, obs_busy, obs_sw, obs_cs, obs_cpi);
        end
        total++; if (cpi_start !== 1'b0) begin bad++; $display("FAIL cpi_start_strobe got=%b want=0", cpi_start); end
    endtask

    task automatic test_pulse_mode();
        chan_en = 4'b1111;
        pulse_clear();
        load_idle(mk(10, 2, 0, 50, 1, 4));
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin pulse_clear(); load_idle(mk(10, 2, 0, 50, 1, 0)); end
            do_txn(0, m_act);
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL pulse_busy%0d got=%0d want=%0d", i, obs_busy, exp_busy); end
            total++; if (obs_sw !== exp_sw) begin bad++; $display("FAIL pulse_switch%0d got=%b want=%b", i, obs_sw, exp_sw); end
            total++; if (obs_plen !== exp_plen) begin bad++; $display("FAIL pulse_width%0d got=%0d want=%0d", i, obs_plen, exp_plen); end
            $display("pulse %0d: busy=%0d switch=%b width=%0d", i, obs_busy, obs_sw, obs_plen);
        end
    endtask

    task automatic test_err_overrun();
        pulse_clear();
        load_idle(mk(20, 30, 0, 10, 0, 1));
        do_txn(0, m_act);
        total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL err_busy got=%0d want=%0d", obs_busy, exp_busy); end
        total++; if (obs_err !== m_err) begin bad++; $display("FAIL err_flag got=%b want=%b", obs_err, m_err); end
        total++; if (obs_ovr !== m_ovr) begin bad++; $display("FAIL err_no_overrun got=%b want=%b", obs_ovr, m_ovr); end
        $display("cfg_err: busy=%0d cfg_err=%b overrun=%b", obs_busy, obs_err, obs_ovr);
        load_idle(mk(100, 0, 0, 10, 0, 1));
        pulse_clear();
        @(negedge clk);
        total++; if (cfg_err !== m_err) begin bad++; $display("FAIL err_cleared got=%b want=%b", cfg_err, m_err); end
        do_txn(2, m_act);
        total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL ovr_busy got=%0d want=%0d", obs_busy, exp_busy); end
        total++; if (obs_ovr !== m_ovr) begin bad++; $display("FAIL ovr_flag got=%b want=%b", obs_ovr, m_ovr); end
        total++; if (obs_err !== m_err) begin bad++; $display("FAIL ovr_err got=%b want=%b", obs_err, m_err); end
        $display("overrun: busy=%0d overrun=%b cfg_err=%b", obs_busy, obs_ovr, obs_err);
    endtask

    task automatic test_clear_rst();
        bit ok;
        pulse_clear();
        load_idle(mk(30, 4, 0, 5, 0, 1));
        for (int i = 0; i < 2; i++) begin
            start_wait(ok);
            total++; if (!ok) begin bad++; $display("FAIL abort%0d_enter busy=%b want=1", i, busy); end
            repeat (5) @(negedge clk);
            if (i == 0) begin
                pulse_clear();
            end else begin
                rst = 1'b1; #1;
                m_reset();
            end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort%0d_busy got=%b want=0", i, busy); end
            total++; if (sw !== INV) begin bad++; $display("FAIL abort%0d_switch got=%b want=%b", i, sw, INV); end
            total++; if (cpi_count !== 8'd0) begin bad++; $display("FAIL abort%0d_cpi got=%0d want=0", i, cpi_count); end
            if (i == 1) begin @(negedge clk); rst = 1'b0; end
            repeat (3) @(negedge clk);
            do_txn(0, m_act);
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL abort%0d_after_busy got=%0d want=%0d", i, obs_busy, exp_busy); end
            $display("abort %0d: busy after=%0d switch=%b", i, obs_busy, obs_sw);
        end
    endtask

    task automatic test_nch_cfg_wait();
        pulse_clear();
        chan_en = 4'b0110;
        @(negedge clk);
        total++; if (sw !== 4'b1010) begin bad++; $display("FAIL nch_idle got=%b want=1010", sw); end
        load_idle(mk(20, 5, 3, 1, 0, 1));
        for (int i = 0; i < 3; i++) begin
            do_txn((i == 0) ? 1 : 0, mk(12, 2, 0, 1, 0, 1));
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL nch_busy%0d got=%0d want=%0d", i, obs_busy, exp_busy); end
            total++; if (obs_sw !== exp_sw) begin bad++; $display("FAIL nch_switch%0d got=%b want=%b", i, obs_sw, exp_sw); end
            total++; if (obs_cs !== exp_cs) begin bad++; $display("FAIL nch_cpi_start%0d got=%b want=%b", i, obs_cs, exp_cs); end
            if (i == 0) begin
                total++; if (obs_sw !== 4'b1100) begin bad++; $display("FAIL nch_toggle got=%b want=1100", obs_sw); end
            end
            $display("nch fire %0d: busy=%0d switch=%b cpi_start=%b", i, obs_busy, obs_sw, obs_cs);
        end
    endtask

    task automatic test_random();
        mcfg_t c;
        int act;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) pulse_clear();
            chan_en = 4'($urandom);
            @(negedge clk);
            c = mk($urandom_range(1, 40), $urandom_range(0, 45), $urandom_range(0, 15),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
            act = 0;
            if ($urandom_range(0, 2) == 0) load_idle(c);
            else if (m_target(m_cpi == m_act.cpi_len) >= 8 && $urandom_range(0, 1) == 1) act = 1;
            do_txn(act, c);
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL rnd_busy%0d got=%0d want=%0d", i, obs_busy, exp_busy); end
            total++; if (obs_sw !== exp_sw) begin bad++; $display("FAIL rnd_switch%0d got=%b want=%b", i, obs_sw, exp_sw); end
            total++; if (obs_cs !== exp_cs) begin bad++; $display("FAIL rnd_cpi_start%0d got=%b want=%b", i, obs_cs, exp_cs); end
            total++; if (obs_cpi !== 8'(exp_cpi)) begin bad++; $display("FAIL rnd_cpi%0d got=%0d want=%0d", i, obs_cpi, exp_cpi); end
            total++; if (obs_err !== m_err) begin bad++; $display("FAIL rnd_err%0d got=%b want=%b", i, obs_err, m_err); end
            total++; if (obs_plen !== exp_plen) begin bad++; $display("FAIL rnd_width%0d got=%0d want=%0d", i, obs_plen, exp_plen); end
            $display("rnd %0d: act=%0d busy=%0d switch=%b cpi_start=%b cpi=%0d err=%b width=%0d",
                     i, act, obs_busy, obs_sw, obs_cs, obs_cpi, obs_err, obs_plen);
        end
    endtask

    initial begin
        m_def = mk(2400, 9, 0, 99, 0, 1);
        test_reset();
        test_defaults();
        test_cpi_boundary();
        test_pulse_mode();
        test_err_overrun();
        test_clear_rst();
        test_nch_cfg_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
